packet_byte_framer: RTL and testbench



---
 rtl/packet_byte_framer_pkg.sv | 30 +++
 rtl/packet_byte_framer_checksum.sv | 36 +++
 rtl/packet_byte_framer.sv | 185 ++++++++++++++++++
 tb/tb_packet_byte_framer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_byte_framer_pkg.sv
// Shared definitions for the packet byte framer: FSM encoding, ASCII
// constants and small helpers used by the framer datapath.
package packet_byte_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DATA    = 3'd1,
    ST_CSUM_HI = 3'd2,
    ST_CSUM_LO = 3'd3,
    ST_TERM    = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

  // Upper-case ASCII hex digit for one nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_ZERO + {4'h0, nib};
    end
    return ASCII_A + {4'h0, nib} - 8'd10;
  endfunction

  // Number of whole bytes in a packet of the given bit width.
  function automatic int bytes_in(input int packet_size);
    return packet_size / 8;
  endfunction

endpackage

// File: rtl/packet_byte_framer_checksum.sv
// Frame checksum: XOR accumulator over the raw packet bytes. Clear has
// priority over accumulate so a new frame can start on a transfer edge.
module packet_byte_framer_checksum (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] value
);

  logic [7:0] csum_q;
  logic [7:0] csum_d;

  // Next checksum: clear, fold in one byte, or hold.
  always_comb begin
    csum_d = csum_q;
    if (clear) begin
      csum_d = 8'h00;
    end else if (en) begin
      csum_d = csum_q ^ din;
    end
  end

  // Checksum register.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign value = csum_q;

endmodule

// File: rtl/packet_byte_framer.sv
// Packet byte framer: serialises a latched packet snapshot MSB first as raw
// bytes or ASCII hex, appends an XOR checksum (and CR in hex mode), and
// counts packets that arrive while a frame is still being sent.
module packet_byte_framer
  import packet_byte_framer_pkg::*;
#(
  parameter int PACKET_SIZE = 256,
  parameter int BINARY      = 0,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                   sysclk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [PACKET_SIZE-1:0] packet,
  input  logic                   packet_strobe,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   clear_overrun,
  output logic [DROP_WIDTH-1:0]  drop_count
);

  localparam int NUM_BYTES = bytes_in(PACKET_SIZE);
  localparam int IW        = $clog2(PACKET_SIZE / 4) + 1;
  localparam logic [IW-1:0] LAST_IDX =
    (BINARY != 0) ? IW'(NUM_BYTES - 1) : IW'(2 * NUM_BYTES - 1);

  state_t                  state_q, state_d;
  logic [IW-1:0]           index_q, index_d;
  logic [PACKET_SIZE-1:0]  shadow_q, shadow_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    overrun_q, overrun_d;
  logic [DROP_WIDTH-1:0]   drop_q, drop_d;

  logic                    csum_clear;
  logic                    csum_en;
  logic [7:0]              csum_value;
  logic [IW+2:0]           shamt;
  logic [7:0]              data_byte;
  logic [7:0]              tx_byte_c;
  logic                    xfer;
  logic                    frame_done;
  logic                    accept;
  logic                    drop;

  // The index counts bytes in binary mode and nibbles in hex mode; shifting
  // by it puts the current element in the top bits. In hex mode, at an even
  // nibble index the top byte is exactly the raw byte being checksummed.
  assign shamt     = (BINARY != 0) ? {index_q, 3'b000} : {1'b0, index_q, 2'b00};
  assign data_byte = 8'((shadow_q << shamt) >> (PACKET_SIZE - 8));

  packet_byte_framer_checksum u_checksum (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .clear   (csum_clear),
    .en      (csum_en),
    .din     (data_byte),
    .value   (csum_value)
  );

  // Byte offered to the transmitter, derived from state so it is stable
  // for as long as the state/index hold during a stall.
  always_comb begin
    tx_byte_c = 8'h00;
    if (tx_valid_q) begin
      case (state_q)
        ST_DATA:    tx_byte_c = (BINARY != 0) ? data_byte : nibble_to_ascii(data_byte[7:4]);
        ST_CSUM_HI: tx_byte_c = nibble_to_ascii(csum_value[7:4]);
        ST_CSUM_LO: tx_byte_c = (BINARY != 0) ? csum_value : nibble_to_ascii(csum_value[3:0]);
        ST_TERM:    tx_byte_c = ASCII_CR;
        default:    tx_byte_c = 8'h00;
      endcase
    end
  end

  // Next-state, handshake, packet accept/drop and overrun bookkeeping.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    shadow_d   = shadow_q;
    tx_valid_d = tx_valid_q;
    overrun_d  = overrun_q;
    drop_d     = drop_q;
    csum_clear = 1'b0;
    csum_en    = 1'b0;
    frame_done = 1'b0;
    xfer       = tx_valid_q && tx_ready;

    case (state_q)
      ST_IDLE: begin
      end
      ST_DATA: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
        end else if (xfer) begin
          csum_en = (BINARY != 0) || !index_q[0];
          if (index_q == LAST_IDX) begin
            state_d = (BINARY != 0) ? ST_CSUM_LO : ST_CSUM_HI;
          end else begin
            index_d = index_q + IW'(1);
          end
        end
      end
      ST_CSUM_HI: begin
        if (xfer) state_d = ST_CSUM_LO;
      end
      ST_CSUM_LO: begin
        if (xfer) begin
          if (BINARY != 0) frame_done = 1'b1;
          else             state_d    = ST_TERM;
        end
      end
      ST_TERM: begin
        if (xfer) frame_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_done) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
      index_d    = '0;
    end

    // A strobe coinciding with the last transfer starts the next frame
    // directly; any other strobe during a frame is a drop.
    accept = enable && packet_strobe && ((state_q == ST_IDLE) || frame_done);
    drop   = enable && packet_strobe && (state_q != ST_IDLE) && !frame_done;

    if (accept) begin
      shadow_d   = packet;
      csum_clear = 1'b1;
      index_d    = '0;
      state_d    = ST_DATA;
      tx_valid_d = 1'b0;
    end

    if (!enable) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
      index_d    = '0;
    end

    if (clear_overrun) begin
      overrun_d = 1'b0;
      drop_d    = '0;
    end
    if (drop) begin
      overrun_d = 1'b1;
      if (clear_overrun) begin
        drop_d = DROP_WIDTH'(1);
      end else if (drop_q != {DROP_WIDTH{1'b1}}) begin
        drop_d = drop_q + DROP_WIDTH'(1);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      shadow_q   <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      shadow_q   <= shadow_d;
      tx_valid_q <= tx_valid_d;
      overrun_q  <= overrun_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_byte    = tx_byte_c;
  assign tx_valid   = tx_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = overrun_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_packet_byte_framer.sv
// Bench for packet_byte_framer: one hex-mode and one binary-mode instance
// (16-bit packets), checked against a frame model built from the packet.
module tb_packet_byte_framer;

  typedef logic [7:0] bq_t [$];

  typedef struct {
    logic [15:0] pkt;
    logic [7:0]  exp_first;
    logic [7:0]  exp_csum;
  } bin_vec_t;

  logic        sysclk = 1'b0;
  logic        reset_n;

  logic        en_h, stb_h, clr_h, rdy_h;
  logic [15:0] pkt_h;
  logic [7:0]  byte_h, drop_h;
  logic        val_h, busy_h, ovr_h;

  logic        en_b, stb_b, clr_b, rdy_b;
  logic [15:0] pkt_b;
  logic [7:0]  byte_b, drop_b;
  logic        val_b, busy_b, ovr_b;

  int vectors    = 0;
  int miscompares = 0;

  int rdy_mode_h = 0;
  int rdy_mode_b = 0;
  int pat_i      = 0;
  bit pat [4]    = '{1'b1, 1'b0, 1'b0, 1'b1};

  bq_t cap_h;
  bq_t cap_b;

  logic       stall_h_prev = 1'b0, stall_b_prev = 1'b0;
  logic [7:0] held_h = 8'h00, held_b = 8'h00;

  packet_byte_framer #(.PACKET_SIZE(16), .BINARY(0), .DROP_WIDTH(8)) u_hex (
    .sysclk(sysclk), .reset_n(reset_n), .enable(en_h), .packet(pkt_h),
    .packet_strobe(stb_h), .tx_byte(byte_h), .tx_valid(val_h), .tx_ready(rdy_h),
    .busy(busy_h), .overrun(ovr_h), .clear_overrun(clr_h), .drop_count(drop_h)
  );

  packet_byte_framer #(.PACKET_SIZE(16), .BINARY(1), .DROP_WIDTH(8)) u_bin (
    .sysclk(sysclk), .reset_n(reset_n), .enable(en_b), .packet(pkt_b),
    .packet_strobe(stb_b), .tx_byte(byte_b), .tx_valid(val_b), .tx_ready(rdy_b),
    .busy(busy_b), .overrun(ovr_b), .clear_overrun(clr_b), .drop_count(drop_b)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Expected frame from the packet: raw bytes or hex digits, XOR checksum,
  // and CR terminator in hex mode.
  function automatic bq_t build_frame(input logic [15:0] p, input bit bin);
    bq_t        q;
    string      hexdig;
    logic [7:0] b;
    logic [7:0] cs;
    hexdig = "0123456789ABCDEF";
    cs = 8'h00;
    q = {};
    for (int i = 0; i < 2; i++) begin
      b = p[15 - 8*i -: 8];
      cs = cs ^ b;
      if (bin) begin
        q.push_back(b);
      end else begin
        q.push_back(8'(hexdig[int'(b[7:4])]));
        q.push_back(8'(hexdig[int'(b[3:0])]));
      end
    end
    if (bin) begin
      q.push_back(cs);
    end else begin
      q.push_back(8'(hexdig[int'(cs[7:4])]));
      q.push_back(8'(hexdig[int'(cs[3:0])]));
      q.push_back(8'h0D);
    end
    return q;
  endfunction

  task automatic compare_q(input string name, input bq_t got, input bq_t exp);
    check($sformatf("%s_len", name), got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
    end
  endtask

  // Transfer capture and stall-stability monitor.
  always @(negedge sysclk) begin
    if (reset_n) begin
      if (val_h && rdy_h) cap_h.push_back(byte_h);
      if (val_b && rdy_b) cap_b.push_back(byte_b);
    end
    if (stall_h_prev && en_h && reset_n) begin
      check("hold_valid_h", val_h, 1'b1);
      check("hold_byte_h", byte_h, held_h);
    end
    if (stall_b_prev && en_b && reset_n) begin
      check("hold_valid_b", val_b, 1'b1);
      check("hold_byte_b", byte_b, held_b);
    end
    stall_h_prev <= reset_n && en_h && val_h && !rdy_h;
    stall_b_prev <= reset_n && en_b && val_b && !rdy_b;
    held_h <= byte_h;
    held_b <= byte_b;
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
    if (rdy_mode_h == 1) rdy_h = 1'($urandom_range(0, 1));
    else if (rdy_mode_h == 2) begin
      rdy_h = pat[pat_i % 4];
      pat_i++;
    end
    if (rdy_mode_b == 1) rdy_b = 1'($urandom_range(0, 1));
  endtask

  task automatic start(input bit bin, input logic [15:0] p);
    if (bin) begin pkt_b = p; stb_b = 1'b1; end
    else     begin pkt_h = p; stb_h = 1'b1; end
    tick();
    stb_b = 1'b0;
    stb_h = 1'b0;
  endtask

  task automatic wait_idle(input bit bin, input int budget, output int cycles);
    cycles = 0;
    while ((bin ? busy_b : busy_h) && cycles < budget) begin
      tick();
      cycles++;
    end
    if (cycles >= budget) check("idle_timeout", bin ? busy_b : busy_h, 1'b0);
  endtask

  initial begin
    bin_vec_t tbl [6];
    bq_t      exp;
    bq_t      tmp;
    int       cyc;
    int       n;
    logic [15:0] rp;

    tbl[0] = '{16'hA53C, 8'hA5, 8'h99};
    tbl[1] = '{16'h0001, 8'h00, 8'h01};
    tbl[2] = '{16'hFFFF, 8'hFF, 8'h00};
    tbl[3] = '{16'h1234, 8'h12, 8'h26};
    tbl[4] = '{16'h8000, 8'h80, 8'h80};
    tbl[5] = '{16'h0F0F, 8'h0F, 8'h00};

    reset_n = 1'b0;
    en_h = 1'b1; stb_h = 1'b0; clr_h = 1'b0; rdy_h = 1'b1; pkt_h = 16'h0;
    en_b = 1'b1; stb_b = 1'b0; clr_b = 1'b0; rdy_b = 1'b1; pkt_b = 16'h0;
    #23;
    check("rst_valid_h", val_h, 1'b0);
    check("rst_busy_h", busy_h, 1'b0);
    check("rst_byte_h", byte_h, 8'h00);
    check("rst_ovr_h", ovr_h, 1'b0);
    check("rst_drop_h", drop_h, 8'h00);
    check("rst_valid_b", val_b, 1'b0);
    check("rst_busy_b", busy_b, 1'b0);
    @(negedge sysclk);
    reset_n = 1'b1;
    tick();

    // Binary frame, latency and back-to-back timing.
    cap_b.delete();
    start(1'b1, 16'hA53C);
    check("b_lat_busy", busy_b, 1'b1);
    check("b_lat_valid0", val_b, 1'b0);
    tick();
    check("b_first_valid", val_b, 1'b1);
    check("b_first_byte", byte_b, 8'hA5);
    wait_idle(1'b1, 50, cyc);
    check("b_b2b_cycles", cyc, 3);
    compare_q("b_A53C", cap_b, build_frame(16'hA53C, 1'b1));

    // Hex frame, same packet.
    cap_h.delete();
    start(1'b0, 16'hA53C);
    check("h_lat_valid0", val_h, 1'b0);
    tick();
    check("h_first_byte", byte_h, 8'h41);
    wait_idle(1'b0, 50, cyc);
    check("h_b2b_cycles", cyc, 7);
    compare_q("h_A53C", cap_h, build_frame(16'hA53C, 1'b0));

    // Hex frame with ready toggling 1-0-0-1.
    cap_h.delete();
    pat_i = 0;
    rdy_mode_h = 2;
    start(1'b0, 16'hA53C);
    wait_idle(1'b0, 100, cyc);
    rdy_mode_h = 0; rdy_h = 1'b1;
    compare_q("h_stall", cap_h, build_frame(16'hA53C, 1'b0));

    // Binary table.
    for (int i = 0; i < 6; i++) begin
      cap_b.delete();
      start(1'b1, tbl[i].pkt);
      wait_idle(1'b1, 50, cyc);
      check($sformatf("tbl%0d_len", i), cap_b.size(), 3);
      if (cap_b.size() == 3) begin
        check($sformatf("tbl%0d_first", i), cap_b[0], tbl[i].exp_first);
        check($sformatf("tbl%0d_csum", i), cap_b[2], tbl[i].exp_csum);
      end
    end

    // Drops while a stalled frame is in flight, with saturation.
    cap_h.delete();
    start(1'b0, 16'hA53C);
    tick(); tick(); tick();
    rdy_h = 1'b0;
    pkt_h = 16'h1234;
    stb_h = 1'b1;
    repeat (256) tick();
    stb_h = 1'b0;
    check("sat_ovr", ovr_h, 1'b1);
    check("sat_drop", drop_h, 8'hFF);
    check("sat_busy", busy_h, 1'b1);
    rdy_h = 1'b1;
    wait_idle(1'b0, 50, cyc);
    compare_q("h_after_drops", cap_h, build_frame(16'hA53C, 1'b0));
    clr_h = 1'b1; tick(); clr_h = 1'b0;
    check("clr_ovr", ovr_h, 1'b0);
    check("clr_drop", drop_h, 8'h00);

    // Clear and drop on the same edge: the drop wins.
    cap_h.delete();
    start(1'b0, 16'hA53C);
    pkt_h = 16'hFFFF; stb_h = 1'b1; clr_h = 1'b1;
    tick();
    clr_h = 1'b0;
    check("clrdrop_ovr", ovr_h, 1'b1);
    check("clrdrop_cnt", drop_h, 8'h01);
    tick();
    stb_h = 1'b0;
    check("drop2_cnt", drop_h, 8'h02);
    clr_h = 1'b1; tick(); clr_h = 1'b0;
    check("clr2_drop", drop_h, 8'h00);
    wait_idle(1'b0, 50, cyc);
    compare_q("h_clrdrop_frame", cap_h, build_frame(16'hA53C, 1'b0));

    // Strobe on the edge of the final CR transfer.
    cap_h.delete();
    start(1'b0, 16'hA53C);
    n = 0;
    while (!(val_h && rdy_h && byte_h == 8'h0D) && n < 50) begin
      tick();
      n++;
    end
    check("find_cr", n < 50, 1'b1);
    pkt_h = 16'h0001; stb_h = 1'b1;
    tick();
    stb_h = 1'b0;
    check("b2b_busy", busy_h, 1'b1);
    check("b2b_valid0", val_h, 1'b0);
    check("b2b_ovr", ovr_h, 1'b0);
    tick();
    check("b2b_first", byte_h, 8'h30);
    wait_idle(1'b0, 50, cyc);
    exp = build_frame(16'hA53C, 1'b0);
    tmp = build_frame(16'h0001, 1'b0);
    foreach (tmp[i]) exp.push_back(tmp[i]);
    compare_q("h_b2b", cap_h, exp);
    check("b2b_drop", drop_h, 8'h00);

    // Abort via enable after two bytes; overrun survives the abort.
    cap_h.delete();
    start(1'b0, 16'hA53C);
    tick();
    stb_h = 1'b1;
    tick();
    stb_h = 1'b0;
    tick();
    check("abort_sent", cap_h.size(), 2);
    en_h = 1'b0;
    tick();
    check("abort_valid", val_h, 1'b0);
    check("abort_busy", busy_h, 1'b0);
    check("abort_ovr", ovr_h, 1'b1);
    check("abort_drop", drop_h, 8'h01);
    stb_h = 1'b1; tick(); stb_h = 1'b0;
    check("dis_busy", busy_h, 1'b0);
    check("dis_drop", drop_h, 8'h01);
    en_h = 1'b1;
    cap_h.delete();
    start(1'b0, 16'hA53C);
    wait_idle(1'b0, 50, cyc);
    compare_q("h_restart", cap_h, build_frame(16'hA53C, 1'b0));
    clr_h = 1'b1; tick(); clr_h = 1'b0;

    // Asynchronous reset mid-frame.
    start(1'b0, 16'hA53C);
    tick(); tick();
    check("pre_rst_valid", val_h, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", val_h, 1'b0);
    check("arst_busy", busy_h, 1'b0);
    check("arst_byte", byte_h, 8'h00);
    @(negedge sysclk);
    reset_n = 1'b1;
    tick();
    check("post_rst_busy", busy_h, 1'b0);
    cap_h.delete();
    start(1'b0, 16'h5AC3);
    wait_idle(1'b0, 50, cyc);
    compare_q("h_post_rst", cap_h, build_frame(16'h5AC3, 1'b0));

    // Randomised packets and ready patterns on both instances.
    rdy_mode_h = 1;
    for (int i = 0; i < 10; i++) begin
      rp = 16'($urandom);
      cap_h.delete();
      start(1'b0, rp);
      wait_idle(1'b0, 400, cyc);
      compare_q($sformatf("rnd_h%0d", i), cap_h, build_frame(rp, 1'b0));
    end
    rdy_mode_h = 0; rdy_h = 1'b1;
    rdy_mode_b = 1;
    for (int i = 0; i < 10; i++) begin
      rp = 16'($urandom);
      cap_b.delete();
      start(1'b1, rp);
      wait_idle(1'b1, 400, cyc);
      compare_q($sformatf("rnd_b%0d", i), cap_b, build_frame(rp, 1'b1));
    end
    rdy_mode_b = 0; rdy_b = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
